// File: rtl/n_bit_adder_pkg.sv
// n_bit_adder_pkg: shared constants for the registered N-bit adder.
// Exports DEFAULT_WIDTH, the default operand/result width.
package n_bit_adder_pkg;

  localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/n_bit_adder_full_adder.sv
// full_adder: one-bit combinational full-adder cell.
// Ports: a, b, cin (inputs); sum, cout (outputs).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_p;

  assign w_p  = a ^ b;
  assign sum  = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/n_bit_adder.sv
// n_bit_adder: registered unsigned ripple-carry adder, sum mod 2^WIDTH.
// Ports: clk, rst (sync, active-high), input1_in, input2_in, answer_out.
module n_bit_adder
  import n_bit_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input1_in,
  input  logic [WIDTH-1:0] input2_in,
  output logic [WIDTH-1:0] answer_out
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_unused_cout;
  logic [WIDTH-1:0] r_answer;

  assign w_carry[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
        .a    (input1_in[i]),
        .b    (input2_in[i]),
        .cin  (w_carry[i]),
        .sum  (w_sum[i]),
        .cout (w_carry[i+1])
      );
    end
  endgenerate

  // carry out of the MSB is dropped: result wraps
  assign w_unused_cout = w_carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) r_answer <= '0;
    else     r_answer <= w_sum;
  end

  assign answer_out = r_answer;

endmodule

// File: tb/tb_n_bit_adder.sv
// tb_n_bit_adder: self-checking bench for n_bit_adder (WIDTH 32 and 8).
// Random and directed vectors against an arithmetic reference model.
module tb_n_bit_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a32, b32, y32;
  logic [7:0]  a8, b8, y8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  n_bit_adder #(.WIDTH(32)) u_dut32 (
    .clk        (clk),
    .rst        (rst),
    .input1_in  (a32),
    .input2_in  (b32),
    .answer_out (y32)
  );

  n_bit_adder #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .input1_in  (a8),
    .input2_in  (b8),
    .answer_out (y8)
  );

  function automatic longint unsigned ref_sum(
    input bit r, input longint unsigned a,
    input longint unsigned b, input int w);
    if (r) return 0;
    return (a + b) % (64'd1 << w);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // apply one operand pair to both instances, check both after the edge
  task automatic step(input bit r,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    logic [31:0] e32;
    logic [31:0] e8;
    rst = r; a32 = a; b32 = b; a8 = c; b8 = d;
    e32 = 32'(ref_sum(r, a, b, 32));
    e8  = 32'(ref_sum(r, c, d, 8));
    @(posedge clk);
    #1;
    chk("model32", y32, e32);
    chk("model8", {24'd0, y8}, e8);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  vec_t dir[$];

  initial begin
    rst = 1'b1; a32 = '0; b32 = '0; a8 = '0; b8 = '0;

    step(1'b1, 0, 0, 0, 0);
    chk("reset", y32, 32'd0);
    step(1'b0, 1, 0, 0, 0);
    chk("first", y32, 32'd1);

    dir = '{
      '{32'd2, 32'd0, 32'd2},
      '{32'd4, 32'd4, 32'd8},
      '{32'd8, 32'd8, 32'd16},
      '{32'd16, 32'd16, 32'd32},
      '{32'd100, 32'd100, 32'd200},
      '{32'd1000, 32'd1000, 32'd2000},
      '{32'd20000, 32'd20000, 32'd40000},
      '{32'd300000, 32'd300000, 32'd600000},
      '{32'd4000000, 32'd4000000, 32'd8000000},
      '{32'd50000000, 32'd50000000, 32'd100000000},
      '{32'd600000000, 32'd600000000, 32'd1200000000},
      '{32'd1, 32'd1, 32'd2},
      '{32'd2, 32'd2, 32'd4},
      '{32'd3, 32'd3, 32'd6},
      '{32'd4, 32'd4, 32'd8},
      '{32'd5, 32'd5, 32'd10},
      '{32'd5, 32'd5, 32'd10},
      '{32'd5, 32'd5, 32'd10},
      '{32'hFFFFFFFF, 32'd1, 32'd0},
      '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
      '{32'h80000000, 32'h80000000, 32'd0},
      '{32'h7FFFFFFF, 32'd1, 32'h80000000},
      '{32'h0000FFFF, 32'd1, 32'h00010000},
      '{32'd0, 32'd0, 32'd0}
    };
    foreach (dir[k]) begin
      step(1'b0, dir[k].a, dir[k].b, 8'd0, 8'd0);
      chk($sformatf("dir%0d", k), y32, dir[k].y);
    end

    step(1'b0, 10, 20, 8'd200, 8'd100);
    chk("mid_pre", y32, 32'd30);
    chk("w8_wrap", {24'd0, y8}, 32'd44);
    step(1'b1, 7, 7, 8'd9, 8'd9);
    chk("mid_rst", y32, 32'd0);
    chk("w8_rst", {24'd0, y8}, 32'd0);
    step(1'b0, 3, 4, 8'd255, 8'd1);
    chk("mid_post", y32, 32'd7);
    chk("w8_edge", {24'd0, y8}, 32'd0);

    step(1'b1, 32'hDEADBEEF, 1, 8'd3, 8'd3);
    step(1'b1, 32'h12345678, 1, 8'd3, 8'd3);
    chk("rst_hold", y32, 32'd0);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] ra, rb;
      bit rr;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(7))
        0: ra = 32'hFFFFFFFF;
        1: rb = ~ra;
        2: rb = (~ra) + 32'd1;
        default: ;
      endcase
      rr = ($urandom_range(15) == 0);
      step(rr, ra, rb, 8'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
